// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: run-control sequencer and counter for a two-digit BCD counter.
// It provides start/stop/clear/load control, up/down counting, a clock prescaler,
// and either wrap-around or one-shot handling at the ends of the range.
//
// Ports
//   clk        in   1  clock, rising edge
//   reset      in   1  asynchronous, active-high
//   start      in   1  begins (IDLE) or resumes (PAUSE) counting
//   stop       in   1  pauses counting (RUN -> PAUSE); wins over start
//   clear      in   1  count := 00, prescaler := 0, state := IDLE
//   up_dn      in   1  1 = count up, 0 = count down, sampled at each step
//   load       in   1  one-cycle strobe loading load_tens/load_ones
//   load_tens  in   4  BCD tens digit to load
//   load_ones  in   4  BCD ones digit to load
//   tens       out  4  BCD tens digit (registered)
//   ones       out  4  BCD ones digit (registered)
//   state      out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE (registered)
//   tick       out  1  pulse in the first cycle a new count is visible
//   wrap       out  1  pulse with tick on a wrap or one-shot terminal event
//   load_err   out  1  pulse after a rejected load
module bcd_count_ctrl #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned TERMINAL = 99,
    parameter int unsigned ONE_SHOT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] state,
    output logic       tick,
    output logic       wrap,
    output logic       load_err
);

    localparam int unsigned      PSC_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST    = PSC_W'(PRESCALE - 1);
    localparam logic [3:0]       TERM_TENS   = 4'(TERMINAL / 10);
    localparam logic [3:0]       TERM_ONES   = 4'(TERMINAL % 10);
    localparam logic             ONE_SHOT_EN = (ONE_SHOT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic [3:0] up_tens, up_ones;
    logic [3:0] dn_tens, dn_ones;
    logic       at_term, at_zero, load_ok, psc_done;

    // BCD increment/decrement of the current count, digit-wise with carry/borrow
    always_comb begin : bcd_step
        up_tens = tens_q;
        up_ones = ones_q + 4'd1;
        if (ones_q == 4'd9) begin
            up_ones = 4'd0;
            up_tens = tens_q + 4'd1;
        end
        dn_tens = tens_q;
        dn_ones = ones_q - 4'd1;
        if (ones_q == 4'd0) begin
            dn_ones = 4'd9;
            dn_tens = tens_q - 4'd1;
        end
    end

    assign at_term  = (tens_q == TERM_TENS) && (ones_q == TERM_ONES);
    assign at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign psc_done = (psc_q == PSC_LAST);

    // A load must be two BCD digits whose decimal value does not exceed TERMINAL
    assign load_ok = (load_tens <= 4'd9) && (load_ones <= 4'd9) &&
                     ((load_tens < TERM_TENS) ||
                      ((load_tens == TERM_TENS) && (load_ones <= TERM_ONES)));

    // Next-state: command priority clear > load > stop > start, then prescaled counting
    always_comb begin : next_state
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        psc_d      = psc_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;

        if (clear) begin
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            psc_d   = '0;
            state_d = IDLE;
        end else if (load) begin
            // A rejected load still takes the cycle: nothing advances
            if (load_ok) begin
                tens_d = load_tens;
                ones_d = load_ones;
                psc_d  = '0;
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end else begin
                load_err_d = 1'b1;
            end
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (start && (state_q == IDLE)) begin
            state_d = RUN;
            psc_d   = '0;
        end else if (start && (state_q == PAUSE)) begin
            // Prescaler keeps its held value so no partial period is lost
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (!psc_done) begin
                psc_d = psc_q + PSC_W'(1);
            end else begin
                psc_d  = '0;
                tick_d = 1'b1;
                if (up_dn) begin
                    if (at_term) begin
                        wrap_d = 1'b1;
                        if (ONE_SHOT_EN) begin
                            state_d = DONE;
                        end else begin
                            tens_d = 4'd0;
                            ones_d = 4'd0;
                        end
                    end else begin
                        tens_d = up_tens;
                        ones_d = up_ones;
                    end
                end else begin
                    if (at_zero) begin
                        wrap_d = 1'b1;
                        if (ONE_SHOT_EN) begin
                            state_d = DONE;
                        end else begin
                            tens_d = TERM_TENS;
                            ones_d = TERM_ONES;
                        end
                    end else begin
                        tens_d = dn_tens;
                        ones_d = dn_ones;
                    end
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin : regs
        if (reset) begin
            state_q    <= IDLE;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            psc_q      <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            psc_q      <= psc_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign tens     = tens_q;
    assign ones     = ones_q;
    assign state    = state_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule
